mdu_iter: RTL
=============

# mdu_iter

Parametrised multiply/divide unit for the execute stage of the pipelined MIPS core: a successor to the fixed 32-bit MDU. It supports configurable datapath width and multiply latency, a true iterative restoring divider, and accumulate modes (madd/msub). Results are held in HI/LO. Busy is signalled to the hazard unit, and new starts are cancelled on an exception/interrupt request.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be even and ≥ 8.
- `MUL_CYCLES`, default 5: busy cycles for mult/madd/msub. Must be ≥ 1.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising edge resets the block
- `Req`  in  1  exception/interrupt request from CP0; blocks any start or HI/LO write in the same cycle
- `MDUOp`  in  4  operation code (see mdu_pkg)
- `rs`  in  WIDTH  operand A (forwarded rs value from the E stage)
- `rt`  in  WIDTH  operand B (forwarded rt value from the E stage)
- `Busy`  out  1  registered; high while an operation is in flight
- `MDUOut`  out  WIDTH  combinational; equals HI for MFHI, LO for MFLO, otherwise 0

## Operation
- Op codes:
  - 0 NONE
  - 1 MULT, 2 MULTU
  - 3 DIV, 4 DIVU
  - 5 MFHI, 6 MFLO
  - 7 MTHI, 8 MTLO
  - 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU
- Start ops are 1–4 and 9–12. A start is accepted only when `Busy==0 && Req==0`. When `Busy==1` a start is ignored; the hazard unit must stall any MDU op in E while Busy is high.
- Operands are latched at acceptance; later changes to `rs`/`rt` have no effect.
- MTHI/MTLO write HI/LO at the next edge only when `Busy==0 && Req==0`; otherwise they are ignored.
- MFHI/MFLO read the committed HI/LO. They never see partial results.
- MULT/MULTU: {HI,LO} = 2·WIDTH-bit signed/unsigned product.
- MADD(U)/MSUB(U): {HI,LO} = {HI,LO} ± product, using HI/LO as they stand at commit, wrapping modulo 2^(2·WIDTH).
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN_INT / −1 gives LO = MIN_INT, HI = 0.
  - Divisor 0: the op runs its full latency, then HI/LO stay unchanged.
- Divider: radix-2 restoring, one quotient bit per cycle on operand magnitudes. Sign fixup is applied at commit.
- State machine:
  - IDLE → MUL on an accepted mult-class start, with the counter loaded to MUL_CYCLES−1.
  - IDLE → DIV on an accepted div-class start, with the counter loaded to WIDTH−1.
  - MUL/DIV: the counter decrements each cycle. When counter==0: commit HI/LO and go to IDLE.
- `Req` does not abort an in-flight op; it completes and commits. Keeping madd/msub correct when a victim instruction is re-executed is handled by the exception entry logic, not this block.
- Reset:
  - State ← IDLE, counter ← 0, HI ← 0, LO ← 0, `Busy` ← 0.
  - A reset mid-operation aborts with no commit.

## Timing
- Start accepted at edge t0: `Busy` is high in cycles t0+1 … t0+L.
  - L = MUL_CYCLES for mult-class ops; L = WIDTH for div-class ops.
  - HI/LO commit at the edge ending cycle t0+L. In cycle t0+L+1, `Busy==0` and MFHI/MFLO return the new value.
- Back-to-back: a new start can be accepted in cycle t0+L+1.
- MTHI/MTLO: the write lands at the following edge, so an MFHI in the next cycle sees the new value.
- `MDUOut` has zero latency (purely combinational from HI/LO and MDUOp).
- Simultaneous commit and any MT op cannot happen, because MT is ignored while Busy is high.
- `Req` and a start in the same cycle: the start is dropped and the state stays IDLE.

## Structure
- Package `mdu_pkg` holds:
  - the MDU op-code localparams (4-bit);
  - state encodings IDLE/MUL/DIV;
  - a helper predicate classifying start / mult-class / div-class ops.
- Sub-module `mdu_divider`: WIDTH-parametrised unsigned iterative restoring core.
  - Ports: load, magnitude operands, step enable, quotient/remainder outputs.
  - The top block handles operand sign extraction, the latency counter, HI/LO, and sign fixup.
- The multiply product is computed from the latched operands, then held until the counter expires.

## Test plan
All scenarios use WIDTH=32, MUL_CYCLES=5.
1. MULT, rs=0xFFFFFFFD (−3), rt=7 → Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
2. DIV, rs=−7, rt=2 → Busy for 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 → LO=0x0FFFFFFF, HI=0xF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
3. MTHI 0x1234, MTLO 0x5678, then DIV 5/0 → Busy for 32 cycles, then HI=0x1234, LO=0x5678.
4. HI=0, LO=0xFFFFFFFF, MADDU 1·1 → HI=1, LO=0. Then with HI=LO=0, MSUB 1·1 → HI=LO=0xFFFFFFFF.
5. Rejected requests:
   - Start with Req=1 → Busy stays 0 and HI/LO are unchanged.
   - Start while Busy → ignored; the first result is committed unaltered.
   - MTLO while Busy → ignored.
6. reset=0 during cycle 10 of a DIV → at the next cycle Busy=0, HI=LO=0, and no later commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU op codes, state encoding and op classification helpers
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_start_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - unsigned radix-2 restoring divider core, one quotient bit per step
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Outputs are the result of the step in progress, so the final step can be committed directly
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            quotient  = {quo_q[WIDTH-2:0], 1'b1};
            remainder = diff[WIDTH-1:0];
        end else begin
            quotient  = {quo_q[WIDTH-2:0], 1'b0};
            remainder = shifted[WIDTH-1:0];
        end
    end

    // Partial remainder / quotient shift register, dividend bits shift out of quo_q as quotient bits shift in
    always_ff @(posedge clk) begin
        if (!reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit with HI/LO, accumulate ops and busy signalling
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             Busy,
    output logic [WIDTH-1:0] MDUOut
);

    localparam int MAX_LAT = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    mdu_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             busy_q;
    logic             accept, commit, mt_hi, mt_lo;
    logic [WIDTH-1:0] hi, lo;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             neg_q, neg_r, div_zero;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] div_quo, div_rem, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, hilo_mul;

    assign Busy = busy_q;

    // Operand signs and magnitudes for the divider; only signed divides take magnitudes
    always_comb begin
        sgn_a = is_signed_op(MDUOp) & rs[WIDTH-1];
        sgn_b = is_signed_op(MDUOp) & rt[WIDTH-1];
        mag_a = sgn_a ? (~rs + 1'b1) : rs;
        mag_b = sgn_b ? (~rt + 1'b1) : rt;
    end

    // Next state, latency counter, start acceptance and MT write enables
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        accept   = (state == ST_IDLE) && !Req && is_start_op(MDUOp);
        mt_hi    = (state == ST_IDLE) && !Req && (MDUOp == OP_MTHI);
        mt_lo    = (state == ST_IDLE) && !Req && (MDUOp == OP_MTLO);
        case (state)
            ST_IDLE: begin
                if (accept && is_mul_op(MDUOp)) begin
                    state_nx = ST_MUL;
                    cnt_nx   = CNT_W'(MUL_CYCLES - 1);
                end else if (accept) begin
                    state_nx = ST_DIV;
                    cnt_nx   = CNT_W'(WIDTH - 1);
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt == '0) begin
                    commit   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, counter and registered busy flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy_q <= (state_nx != ST_IDLE);
        end
    end

    // Latch operands and divide sign-fixup flags when a start is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= OP_NONE;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            op_q     <= MDUOp;
            a_q      <= rs;
            b_q      <= rt;
            neg_q    <= sgn_a ^ sgn_b;
            neg_r    <= sgn_a;
            div_zero <= (rt == '0);
        end
    end

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && is_div_op(MDUOp)),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .step      (state == ST_DIV),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Product from the held operands (sign-extended for signed ops), then accumulate onto HI/LO
    always_comb begin
        ext_a   = {{WIDTH{is_signed_op(op_q) & a_q[WIDTH-1]}}, a_q};
        ext_b   = {{WIDTH{is_signed_op(op_q) & b_q[WIDTH-1]}}, b_q};
        prod    = ext_a * ext_b;
        quo_fix = neg_q ? (~div_quo + 1'b1) : div_quo;
        rem_fix = neg_r ? (~div_rem + 1'b1) : div_rem;
        case (op_q)
            OP_MADD, OP_MADDU: hilo_mul = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: hilo_mul = {hi, lo} - prod;
            default:           hilo_mul = prod;
        endcase
    end

    // HI/LO: commit of the finished op, or an MTHI/MTLO write while idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (is_div_op(op_q)) begin
                if (!div_zero) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end else begin
                {hi, lo} <= hilo_mul;
            end
        end else begin
            if (mt_hi) hi <= rs;
            if (mt_lo) lo <= rs;
        end
    end

    // Zero-latency read port for MFHI/MFLO
    always_comb begin
        case (MDUOp)
            OP_MFHI: MDUOut = hi;
            OP_MFLO: MDUOut = lo;
            default: MDUOut = '0;
        endcase
    end

endmodule
